// File: rtl/bitstream_loader.sv
// Serial configuration loader: streams bitstream bytes LSB-first into the
// connection scan chain, then the CLB scan chain, with a two-cycle scan clock.
module bitstream_loader #(
    parameter int CONN_CHAIN_LEN = 512,
    parameter int CLB_CHAIN_LEN  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       scan_clk,
    output logic       conn_scan_in,
    output logic       conn_scan_en,
    output logic       clb_scan_in,
    output logic       clb_scan_en,
    output logic       core_reset,
    output logic       busy,
    output logic       done
);

    localparam int MAX_LEN = (CONN_CHAIN_LEN > CLB_CHAIN_LEN) ? CONN_CHAIN_LEN : CLB_CHAIN_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] CONN_LAST = CNT_W'(CONN_CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CLB_LAST  = CNT_W'(CLB_CHAIN_LEN - 1);
    localparam logic CH_CONN = 1'b0;
    localparam logic CH_CLB  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SHIFT_LO, S_SHIFT_HI, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             chain_q, chain_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       byte_q, byte_d;

    logic cfg_ready_q, cfg_ready_d;
    logic scan_clk_q, scan_clk_d;
    logic conn_scan_in_q, conn_scan_in_d;
    logic conn_scan_en_q, conn_scan_en_d;
    logic clb_scan_in_q, clb_scan_in_d;
    logic clb_scan_en_q, clb_scan_en_d;
    logic core_reset_q, core_reset_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic last_chain_bit;
    logic shifting;
    logic chain_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            chain_q        <= CH_CONN;
            bit_cnt_q      <= '0;
            bit_idx_q      <= '0;
            cfg_ready_q    <= 1'b0;
            scan_clk_q     <= 1'b0;
            conn_scan_in_q <= 1'b0;
            conn_scan_en_q <= 1'b0;
            clb_scan_in_q  <= 1'b0;
            clb_scan_en_q  <= 1'b0;
            core_reset_q   <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            chain_q        <= chain_d;
            bit_cnt_q      <= bit_cnt_d;
            bit_idx_q      <= bit_idx_d;
            cfg_ready_q    <= cfg_ready_d;
            scan_clk_q     <= scan_clk_d;
            conn_scan_in_q <= conn_scan_in_d;
            conn_scan_en_q <= conn_scan_en_d;
            clb_scan_in_q  <= clb_scan_in_d;
            clb_scan_en_q  <= clb_scan_en_d;
            core_reset_q   <= core_reset_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // Byte shift register is pure data; it is always reloaded before use.
    always_ff @(posedge clk) begin
        byte_q <= byte_d;
    end

    always_comb begin
        state_d        = state_q;
        chain_d        = chain_q;
        bit_cnt_d      = bit_cnt_q;
        bit_idx_d      = bit_idx_q;
        byte_d         = byte_q;
        last_chain_bit = (chain_q == CH_CONN) ? (bit_cnt_q == CONN_LAST) : (bit_cnt_q == CLB_LAST);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    chain_d   = CH_CONN;
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                end
            end
            S_FETCH: begin
                if (cfg_valid && cfg_ready_q) begin
                    byte_d    = cfg_data;
                    bit_idx_d = '0;
                    state_d   = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: state_d = S_SHIFT_HI;
            S_SHIFT_HI: begin
                byte_d = {1'b0, byte_q[7:1]};
                if (!last_chain_bit) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_idx_q != 3'd7) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        state_d   = S_SHIFT_LO;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (chain_q == CH_CONN) begin
                    // Remaining bits of this byte are surplus and dropped.
                    chain_d   = CH_CLB;
                    bit_cnt_d = '0;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from next-state values and registered alongside state.
    always_comb begin
        shifting       = (state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI);
        chain_active   = shifting || ((state_d == S_FETCH) && (bit_cnt_d != '0));
        cfg_ready_d    = (state_d == S_FETCH);
        scan_clk_d     = (state_d == S_SHIFT_HI);
        conn_scan_en_d = chain_active && (chain_d == CH_CONN);
        clb_scan_en_d  = chain_active && (chain_d == CH_CLB);
        conn_scan_in_d = shifting && (chain_d == CH_CONN) && byte_d[0];
        clb_scan_in_d  = shifting && (chain_d == CH_CLB) && byte_d[0];
        busy_d         = (state_d != S_IDLE);
        done_d         = (state_d == S_DONE);
        core_reset_d   = core_reset_q;
        if (state_q == S_DONE) begin
            core_reset_d = 1'b0;
        end else if ((state_q == S_IDLE) && start) begin
            core_reset_d = 1'b1;
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign scan_clk     = scan_clk_q;
    assign conn_scan_in = conn_scan_in_q;
    assign conn_scan_en = conn_scan_en_q;
    assign clb_scan_in  = clb_scan_in_q;
    assign clb_scan_en  = clb_scan_en_q;
    assign core_reset   = core_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
